// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types and constants for the coherence bus front end.
// Id widths depend on the requester count, so the package provides a sizing helper.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD    = 2'd0,
    BUS_RDX   = 2'd1,
    BUS_EVICT = 2'd2,
    BUS_INV   = 2'd3
  } bus_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StSnoop,
    StOwn
  } arb_state_t;

  localparam int unsigned SNOOP_TIMEOUT_DEFAULT = 64;

  // Width of cpuid_t: never below one bit so a single-CPU build still has an id.
  function automatic int unsigned id_width(input int unsigned cpus);
    return (cpus > 1) ? $clog2(cpus) : 1;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Request, snoop and grant signals between the L1 requesters and the bus arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface coherence_bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned CPUS = 2
) ();

  localparam int unsigned IdW = id_width(CPUS);

  logic [CPUS-1:0]       req;
  logic [CPUS-1:0][1:0]  req_type;
  logic [CPUS-1:0][31:0] req_addr;
  logic [CPUS-1:0]       ccsnoopdone;
  logic [CPUS-1:0]       ccsnoophit;
  logic                  txn_done;

  logic [CPUS-1:0]       grant;
  logic                  grant_valid;
  logic [IdW-1:0]        grant_id;
  logic [1:0]            grant_type;
  logic [31:0]           grant_addr;
  logic [CPUS-1:0]       snoop_req;
  logic [31:0]           ccsnoopaddr;
  logic                  snoop_valid;
  logic                  snoop_hit_any;
  logic [IdW-1:0]        snoop_hit_id;
  logic                  snoop_timeout;

  modport master (
    output req, req_type, req_addr, ccsnoopdone, ccsnoophit, txn_done,
    input  grant, grant_valid, grant_id, grant_type, grant_addr, snoop_req, ccsnoopaddr,
           snoop_valid, snoop_hit_any, snoop_hit_id, snoop_timeout
  );

  modport slave (
    input  req, req_type, req_addr, ccsnoopdone, ccsnoophit, txn_done,
    output grant, grant_valid, grant_id, grant_type, grant_addr, snoop_req, ccsnoopaddr,
           snoop_valid, snoop_hit_any, snoop_hit_id, snoop_timeout
  );

endinterface

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic [CPUS-1:0]              req,
  input  logic [id_width(CPUS)-1:0]    ptr,
  output logic [CPUS-1:0]              gnt,
  output logic [id_width(CPUS)-1:0]    gnt_id,
  output logic                         any
);

  localparam int unsigned IdW = id_width(CPUS);

  int unsigned    w_idx;
  logic [IdW-1:0] w_sel;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    w_idx  = 0;
    w_sel  = '0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      w_idx = 32'(ptr) + i;
      if (w_idx >= CPUS) begin
        w_idx = w_idx - CPUS;
      end
      w_sel = IdW'(w_idx);
      if (!any && req[w_sel]) begin
        any        = 1'b1;
        gnt[w_sel] = 1'b1;
        gnt_id     = w_sel;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Coherence bus front end: round-robin grant, snoop broadcast and collection with a
// watchdog, then hold ownership until the transfer engine signals txn_done.
module coherence_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned CPUS          = 2,
  parameter int unsigned SNOOP_TIMEOUT = SNOOP_TIMEOUT_DEFAULT
) (
  input logic                    CLK,
  input logic                    nRST,
  coherence_bus_arbiter_if.slave bus
);

  localparam int unsigned IdW = id_width(CPUS);
  localparam int unsigned WdW = $clog2(SNOOP_TIMEOUT + 1);

  typedef logic [IdW-1:0] cpuid_t;

  arb_state_t      r_state, w_state_nxt;
  cpuid_t          r_prio_ptr, w_prio_ptr_nxt;
  logic [CPUS-1:0] r_grant, w_grant_nxt;
  logic            r_grant_valid, w_grant_valid_nxt;
  cpuid_t          r_grant_id, w_grant_id_nxt;
  bus_req_t        r_grant_type, w_grant_type_nxt;
  logic [31:0]     r_grant_addr, w_grant_addr_nxt;
  logic [CPUS-1:0] r_pending, w_pending_nxt;
  logic [CPUS-1:0] r_hit, w_hit_nxt;
  logic            r_hit_any;
  cpuid_t          r_hit_id, w_hit_id;
  logic            r_snoop_valid, w_snoop_valid_nxt;
  logic            r_snoop_timeout, w_snoop_timeout_nxt;
  logic [WdW-1:0]  r_wdog, w_wdog_nxt;

  logic [CPUS-1:0] w_arb_gnt;
  cpuid_t          w_arb_id;
  logic            w_arb_any;
  bus_req_t        w_arb_type;
  logic [CPUS-1:0] w_done_eff;
  logic [CPUS-1:0] w_remain;

  rr_arbiter #(
    .CPUS (CPUS)
  ) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (r_prio_ptr),
    .gnt    (w_arb_gnt),
    .gnt_id (w_arb_id),
    .any    (w_arb_any)
  );

  assign w_arb_type = bus_req_t'(bus.req_type[w_arb_id]);
  // Only pending responders count; the owner is never pending, so its own replies drop out.
  assign w_done_eff = bus.ccsnoopdone & r_pending;
  assign w_remain   = r_pending & ~bus.ccsnoopdone;

  always_comb begin
    w_state_nxt         = r_state;
    w_prio_ptr_nxt      = r_prio_ptr;
    w_grant_nxt         = r_grant;
    w_grant_valid_nxt   = r_grant_valid;
    w_grant_id_nxt      = r_grant_id;
    w_grant_type_nxt    = r_grant_type;
    w_grant_addr_nxt    = r_grant_addr;
    w_pending_nxt       = r_pending;
    w_hit_nxt           = r_hit;
    w_snoop_valid_nxt   = 1'b0;
    w_snoop_timeout_nxt = 1'b0;
    w_wdog_nxt          = r_wdog;

    unique case (r_state)
      StIdle: begin
        if (w_arb_any) begin
          w_grant_nxt       = w_arb_gnt;
          w_grant_valid_nxt = 1'b1;
          w_grant_id_nxt    = w_arb_id;
          w_grant_type_nxt  = w_arb_type;
          w_grant_addr_nxt  = bus.req_addr[w_arb_id];
          w_prio_ptr_nxt    = (32'(w_arb_id) + 1 == CPUS) ? '0 : w_arb_id + 1'b1;
          w_hit_nxt         = '0;
          w_wdog_nxt        = '0;
          if ((CPUS > 1) && (w_arb_type != BUS_EVICT)) begin
            w_pending_nxt = ~w_arb_gnt;
            w_state_nxt   = StSnoop;
          end else begin
            w_state_nxt   = StOwn;
          end
        end
      end

      StSnoop: begin
        w_hit_nxt     = r_hit | (bus.ccsnoophit & w_done_eff);
        w_pending_nxt = w_remain;
        if (w_remain == '0) begin
          w_snoop_valid_nxt = 1'b1;
          w_state_nxt       = StOwn;
        end else if (r_wdog == WdW'(SNOOP_TIMEOUT - 1)) begin
          // Stragglers are resolved as misses: their hit bits were never latched.
          w_snoop_valid_nxt   = 1'b1;
          w_snoop_timeout_nxt = 1'b1;
          w_pending_nxt       = '0;
          w_state_nxt         = StOwn;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end

      StOwn: begin
        if (bus.txn_done) begin
          w_grant_nxt       = '0;
          w_grant_valid_nxt = 1'b0;
          w_grant_id_nxt    = '0;
          w_grant_type_nxt  = BUS_RD;
          w_grant_addr_nxt  = '0;
          w_hit_nxt         = '0;
          w_state_nxt       = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    w_hit_id = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (w_hit_nxt[i]) begin
        w_hit_id = cpuid_t'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= StIdle;
      r_prio_ptr      <= '0;
      r_grant         <= '0;
      r_grant_valid   <= 1'b0;
      r_grant_id      <= '0;
      r_grant_type    <= BUS_RD;
      r_grant_addr    <= '0;
      r_pending       <= '0;
      r_hit           <= '0;
      r_hit_any       <= 1'b0;
      r_hit_id        <= '0;
      r_snoop_valid   <= 1'b0;
      r_snoop_timeout <= 1'b0;
      r_wdog          <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_prio_ptr      <= w_prio_ptr_nxt;
      r_grant         <= w_grant_nxt;
      r_grant_valid   <= w_grant_valid_nxt;
      r_grant_id      <= w_grant_id_nxt;
      r_grant_type    <= w_grant_type_nxt;
      r_grant_addr    <= w_grant_addr_nxt;
      r_pending       <= w_pending_nxt;
      r_hit           <= w_hit_nxt;
      r_hit_any       <= |w_hit_nxt;
      r_hit_id        <= w_hit_id;
      r_snoop_valid   <= w_snoop_valid_nxt;
      r_snoop_timeout <= w_snoop_timeout_nxt;
      r_wdog          <= w_wdog_nxt;
    end
  end

  assign bus.grant         = r_grant;
  assign bus.grant_valid   = r_grant_valid;
  assign bus.grant_id      = r_grant_id;
  assign bus.grant_type    = r_grant_type;
  assign bus.grant_addr    = r_grant_addr;
  assign bus.snoop_req     = r_pending;
  assign bus.ccsnoopaddr   = (r_state == StSnoop) ? r_grant_addr : '0;
  assign bus.snoop_valid   = r_snoop_valid;
  assign bus.snoop_hit_any = r_hit_any;
  assign bus.snoop_hit_id  = r_hit_id;
  assign bus.snoop_timeout = r_snoop_timeout;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench: a 2-CPU arbiter for the basic snoop flow and a 4-CPU arbiter with a
// short watchdog for rotation, evict, timeout, ordering and reset cases.
module tb_coherence_bus_arbiter;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;

  coherence_bus_arbiter_if #(.CPUS(2)) bus2 ();
  coherence_bus_arbiter_if #(.CPUS(4)) bus4 ();

  coherence_bus_arbiter #(
    .CPUS          (2),
    .SNOOP_TIMEOUT (64)
  ) u_dut2 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus2)
  );

  coherence_bus_arbiter #(
    .CPUS          (4),
    .SNOOP_TIMEOUT (8)
  ) u_dut4 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    bus2.req = '0; bus2.req_type = '0; bus2.req_addr = '0;
    bus2.ccsnoopdone = '0; bus2.ccsnoophit = '0; bus2.txn_done = 1'b0;
    bus4.req = '0; bus4.req_type = '0; bus4.req_addr = '0;
    bus4.ccsnoopdone = '0; bus4.ccsnoophit = '0; bus4.txn_done = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Reset state
    check("rst_grant2", 64'(bus2.grant), 64'h0);
    check("rst_valid2", 64'(bus2.grant_valid), 64'h0);
    check("rst_sreq2", 64'(bus2.snoop_req), 64'h0);
    check("rst_grant4", 64'(bus4.grant), 64'h0);
    check("rst_hit4", 64'(bus4.snoop_hit_any), 64'h0);

    // CPUS=2: CPU0 BUS_RD 0x1000, CPU1 done+hit two cycles in
    bus2.req = 2'b01; bus2.req_type[0] = 2'd0; bus2.req_addr[0] = 32'h1000;
    tick();
    check("t1_grant", 64'(bus2.grant), 64'h1);
    check("t1_valid", 64'(bus2.grant_valid), 64'h1);
    check("t1_id", 64'(bus2.grant_id), 64'h0);
    check("t1_sreq", 64'(bus2.snoop_req), 64'h2);
    check("t1_saddr", 64'(bus2.ccsnoopaddr), 64'h1000);
    bus2.req = 2'b00; bus2.req_addr[0] = 32'hdead;
    bus2.txn_done = 1'b1; bus2.ccsnoopdone = 2'b01; bus2.ccsnoophit = 2'b01;
    tick();
    check("t1_ign_sreq", 64'(bus2.snoop_req), 64'h2);
    check("t1_ign_sval", 64'(bus2.snoop_valid), 64'h0);
    check("t1_ign_hit", 64'(bus2.snoop_hit_any), 64'h0);
    check("t1_ign_grant", 64'(bus2.grant), 64'h1);
    bus2.txn_done = 1'b0; bus2.ccsnoopdone = 2'b10; bus2.ccsnoophit = 2'b10;
    tick();
    check("t1_sval", 64'(bus2.snoop_valid), 64'h1);
    check("t1_sreq_clr", 64'(bus2.snoop_req), 64'h0);
    check("t1_hit_any", 64'(bus2.snoop_hit_any), 64'h1);
    check("t1_hit_id", 64'(bus2.snoop_hit_id), 64'h1);
    check("t1_saddr_own", 64'(bus2.ccsnoopaddr), 64'h0);
    check("t1_addr_held", 64'(bus2.grant_addr), 64'h1000);
    bus2.ccsnoopdone = '0; bus2.ccsnoophit = '0;
    tick();
    check("t1_sval_pulse", 64'(bus2.snoop_valid), 64'h0);
    check("t1_hold", 64'(bus2.grant), 64'h1);
    check("t1_hit_held", 64'(bus2.snoop_hit_any), 64'h1);
    bus2.txn_done = 1'b1;
    tick();
    check("t1_rel_grant", 64'(bus2.grant), 64'h0);
    check("t1_rel_valid", 64'(bus2.grant_valid), 64'h0);
    check("t1_rel_hit", 64'(bus2.snoop_hit_any), 64'h0);
    bus2.txn_done = 1'b0;

    // CPUS=4: all requesting EVICT, rotation 0,1,2,3,0 with one idle cycle between
    bus4.req = 4'hf;
    for (int i = 0; i < 4; i++) begin
      bus4.req_type[i] = 2'd2;
      bus4.req_addr[i] = 32'h100 * (i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", 64'(bus4.grant), 64'(1 << (k % 4)));
      check("rr_id", 64'(bus4.grant_id), 64'(k % 4));
      check("rr_addr", 64'(bus4.grant_addr), 64'(32'h100 * ((k % 4) + 1)));
      bus4.txn_done = 1'b1;
      tick();
      check("rr_idle", 64'(bus4.grant), 64'h0);
      bus4.txn_done = 1'b0;
    end
    bus4.req = '0;

    // CPU2 EVICT 0x2040: straight to ownership, no snoop
    bus4.req = 4'b0100; bus4.req_addr[2] = 32'h2040;
    tick();
    check("ev_grant", 64'(bus4.grant), 64'h4);
    check("ev_type", 64'(bus4.grant_type), 64'h2);
    check("ev_addr", 64'(bus4.grant_addr), 64'h2040);
    check("ev_sreq", 64'(bus4.snoop_req), 64'h0);
    check("ev_saddr", 64'(bus4.ccsnoopaddr), 64'h0);
    bus4.req = '0; bus4.txn_done = 1'b1;
    tick();
    check("ev_rel", 64'(bus4.grant), 64'h0);
    bus4.txn_done = 1'b0;

    // CPU1 BUS_RDX; CPU0 hit, CPU2 miss, CPU3 never completes -> watchdog
    bus4.req = 4'b0010; bus4.req_type[1] = 2'd1; bus4.req_addr[1] = 32'h1240;
    tick();
    check("to_grant", 64'(bus4.grant), 64'h2);
    check("to_sreq", 64'(bus4.snoop_req), 64'hd);
    check("to_saddr", 64'(bus4.ccsnoopaddr), 64'h1240);
    bus4.req = '0; bus4.ccsnoopdone = 4'b0101; bus4.ccsnoophit = 4'b1001;
    tick();
    check("to_sreq_left", 64'(bus4.snoop_req), 64'h8);
    check("to_hit_id", 64'(bus4.snoop_hit_id), 64'h0);
    bus4.ccsnoopdone = '0; bus4.ccsnoophit = 4'b1000;
    for (int c = 2; c < 8; c++) tick();
    check("to_early", 64'(bus4.snoop_timeout), 64'h0);
    check("to_pending", 64'(bus4.snoop_req), 64'h8);
    tick();
    check("to_pulse", 64'(bus4.snoop_timeout), 64'h1);
    check("to_sval", 64'(bus4.snoop_valid), 64'h1);
    check("to_sreq_clr", 64'(bus4.snoop_req), 64'h0);
    check("to_hit_any", 64'(bus4.snoop_hit_any), 64'h1);
    check("to_hit_id2", 64'(bus4.snoop_hit_id), 64'h0);
    bus4.ccsnoophit = '0;
    tick();
    check("to_pulse_end", 64'(bus4.snoop_timeout), 64'h0);
    check("to_hold", 64'(bus4.grant), 64'h2);
    bus4.txn_done = 1'b1;
    tick();
    check("to_rel", 64'(bus4.grant_valid), 64'h0);
    bus4.txn_done = 1'b0;

    // CPU2 BUS_INV; CPU3 hit then CPU0 hit, owner's own done ignored; then reset mid-snoop
    bus4.req = 4'b0100; bus4.req_type[2] = 2'd3; bus4.req_addr[2] = 32'h3000;
    tick();
    check("oo_grant", 64'(bus4.grant), 64'h4);
    check("oo_type", 64'(bus4.grant_type), 64'h3);
    check("oo_sreq", 64'(bus4.snoop_req), 64'hb);
    bus4.req = 4'b1001; bus4.ccsnoopdone = 4'b1100; bus4.ccsnoophit = 4'b1100;
    tick();
    check("oo_sreq1", 64'(bus4.snoop_req), 64'h3);
    check("oo_hit_id3", 64'(bus4.snoop_hit_id), 64'h3);
    bus4.ccsnoopdone = 4'b0001; bus4.ccsnoophit = 4'b0001;
    tick();
    check("oo_sreq2", 64'(bus4.snoop_req), 64'h2);
    check("oo_hit_id0", 64'(bus4.snoop_hit_id), 64'h0);
    check("oo_sval", 64'(bus4.snoop_valid), 64'h0);
    bus4.ccsnoopdone = '0; bus4.ccsnoophit = '0;
    nRST = 1'b0;
    #1;
    check("rs_grant", 64'(bus4.grant), 64'h0);
    check("rs_valid", 64'(bus4.grant_valid), 64'h0);
    check("rs_sreq", 64'(bus4.snoop_req), 64'h0);
    check("rs_saddr", 64'(bus4.ccsnoopaddr), 64'h0);
    check("rs_addr", 64'(bus4.grant_addr), 64'h0);
    check("rs_hit", 64'(bus4.snoop_hit_any), 64'h0);
    #3;
    nRST = 1'b1;
    tick();
    check("rs_first", 64'(bus4.grant), 64'h1);
    check("rs_first_id", 64'(bus4.grant_id), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
